// File: rtl/rl_ram_pkg.sv
// Shared types for the rl_ram family: read-during-write policy and clear FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rl_ram_pkg;

  // Same-address read during write: return prior contents or merged write data.
  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_t;

  // Clear sequencer states.
  typedef enum logic {
    RAM_IDLE  = 1'b0,
    RAM_CLEAR = 1'b1
  } ram_clr_state_t;

endpackage

// File: rtl/rl_ram_clr_ctrl.sv
// Clear sequencer: walks every address once, driving a clear write port and busy flag.
// Latency: a clear lasts exactly 2**ABITS cycles; busy drops in the first IDLE cycle.
// Backpressure: clr_i is sampled only in IDLE; requests while busy are ignored.
module rl_ram_clr_ctrl
  import rl_ram_pkg::*;
#(
  parameter int ABITS        = 10,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [ABITS-1:0] clr_addr_o
);

  localparam logic [ABITS-1:0] CNT_ONE = {{(ABITS-1){1'b0}}, 1'b1};

  ram_clr_state_t   state_q, state_d;
  logic [ABITS-1:0] cnt_q, cnt_d;

  // State and address counter registers; reset restarts the sweep at address 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR_ON_RST ? RAM_CLEAR : RAM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: one word cleared per cycle, exit after the last address.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    case (state_q)
      RAM_IDLE: begin
        if (clr_i) begin
          state_d = RAM_CLEAR;
          cnt_d   = '0;
        end
      end
      RAM_CLEAR: begin
        clr_we_o = 1'b1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == '1) begin
          state_d = RAM_IDLE;
        end
      end
      default: begin
        state_d = RAM_IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q == RAM_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/rl_ram_1r1w_fwd.sv
// 1R1W synchronous RAM with byte enables, optional same-address write forwarding and hardware clear.
// Latency: read data and rvalid 1 cycle after acceptance (2 with OUT_REG=1); fully pipelined.
// Backpressure: none; accesses issued while busy (clearing) or during reset are dropped.
module rl_ram_1r1w_fwd
  import rl_ram_pkg::*;
#(
  parameter int               ABITS        = 10,
  parameter int               DBITS        = 32,
  parameter bit               OUT_REG      = 1'b0,
  parameter rdw_mode_t        RDW_MODE     = RDW_NEW,
  parameter bit               CLEAR_ON_RST = 1'b1,
  parameter logic [DBITS-1:0] CLEAR_VAL    = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  output logic                     busy_o,
  input  logic [ABITS-1:0]         waddr_i,
  input  logic [DBITS-1:0]         din_i,
  input  logic                     we_i,
  input  logic [(DBITS+7)/8-1:0]   be_i,
  input  logic [ABITS-1:0]         raddr_i,
  input  logic                     re_i,
  output logic [DBITS-1:0]         dout_o,
  output logic                     rvalid_o
);

  localparam int DEPTH = 2 ** ABITS;

  logic [DBITS-1:0] mem [DEPTH];

  logic             busy;
  logic             clr_we;
  logic [ABITS-1:0] clr_addr;

  logic [DBITS-1:0] wmask;
  logic             wr_acc;
  logic             rd_acc;
  logic [DBITS-1:0] wr_old;
  logic [DBITS-1:0] wr_new;
  logic [DBITS-1:0] rd_old;
  logic             rdw_hit;
  logic [DBITS-1:0] rd1_d;
  logic [DBITS-1:0] rd1_q;
  logic             rv1_q;

  rl_ram_clr_ctrl #(
    .ABITS        (ABITS),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clr_ctrl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign busy_o = busy;

  // Expand byte enables to a bit mask; the top lane may cover fewer than 8 bits.
  for (genvar g = 0; g < DBITS; g++) begin : g_mask
    assign wmask[g] = be_i[g/8];
  end

  assign wr_acc  = we_i & ~busy & ~rst_i;
  assign rd_acc  = re_i & ~busy & ~rst_i;
  assign wr_old  = mem[waddr_i];
  assign wr_new  = (wr_old & ~wmask) | (din_i & wmask);
  assign rd_old  = mem[raddr_i];
  assign rdw_hit = (RDW_MODE == RDW_NEW) && wr_acc && (raddr_i == waddr_i);
  // Forwarded word merges only the enabled lanes over the prior contents.
  assign rd1_d   = rdw_hit ? ((rd_old & ~wmask) | (din_i & wmask)) : rd_old;

  // Storage: the clear port takes priority over user writes (which are dropped while busy anyway).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (clr_we) begin
        mem[clr_addr] <= CLEAR_VAL;
      end else if (wr_acc) begin
        mem[waddr_i] <= wr_new;
      end
    end
  end

  // First read stage: capture data only for accepted reads so the output holds otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rv1_q <= 1'b0;
      rd1_q <= '0;
    end else begin
      rv1_q <= rd_acc;
      if (rd_acc) begin
        rd1_q <= rd1_d;
      end
    end
  end

  if (OUT_REG) begin : g_oreg
    logic [DBITS-1:0] rd2_q;
    logic             rv2_q;

    // Optional output register: one more stage, flushed by reset like the first.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rv2_q <= 1'b0;
        rd2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q) begin
          rd2_q <= rd1_q;
        end
      end
    end

    assign dout_o   = rd2_q;
    assign rvalid_o = rv2_q;
  end else begin : g_noreg
    assign dout_o   = rd1_q;
    assign rvalid_o = rv1_q;
  end

endmodule

// File: tb/tb_rl_ram_1r1w_fwd.sv
// Bench: two instances (OUT_REG=0/RDW_NEW and OUT_REG=1/RDW_OLD) share one stimulus stream.
// A reference memory model fills per-instance scoreboards; a monitor pops them on rvalid.
// Scenario tasks add direct checks on busy timing, flush and hold behaviour.
module tb_rl_ram_1r1w_fwd;
  import rl_ram_pkg::*;

  localparam logic [31:0] CV = 32'h5A5A_0F0F;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst, clr, we, re;
  logic [3:0]  wa, ra, be;
  logic [31:0] din;
  logic        busy_a, busy_b, rv_a, rv_b;
  logic [31:0] dout_a, dout_b;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [31:0] m [16];
  logic [31:0] old_m, mrg_m, mk_m;
  logic [31:0] last_a, last_b;
  int          mcnt;
  int          cyc;
  int          total;
  int          bad;

  rl_ram_1r1w_fwd #(
    .ABITS(4), .DBITS(32), .OUT_REG(1'b0), .RDW_MODE(RDW_NEW),
    .CLEAR_ON_RST(1'b1), .CLEAR_VAL(CV)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy_a),
    .waddr_i(wa), .din_i(din), .we_i(we), .be_i(be),
    .raddr_i(ra), .re_i(re), .dout_o(dout_a), .rvalid_o(rv_a)
  );

  rl_ram_1r1w_fwd #(
    .ABITS(4), .DBITS(32), .OUT_REG(1'b1), .RDW_MODE(RDW_OLD),
    .CLEAR_ON_RST(1'b1), .CLEAR_VAL(CV)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy_b),
    .waddr_i(wa), .din_i(din), .we_i(we), .be_i(be),
    .raddr_i(ra), .re_i(re), .dout_o(dout_b), .rvalid_o(rv_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: clear timing, byte-lane memory and expected read results.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      qa.delete();
      qb.delete();
      mcnt = 16;
    end else if (mcnt != 0) begin
      mcnt = mcnt - 1;
      for (int i = 0; i < 16; i++) m[i] = CV;
    end else begin
      mk_m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      if (re) begin
        old_m = m[ra];
        mrg_m = (old_m & ~mk_m) | (din & mk_m);
        qa.push_back('{dat: ((we && wa == ra) ? mrg_m : old_m), due: cyc});
        qb.push_back('{dat: old_m, due: cyc + 1});
      end
      if (we) m[wa] = (m[wa] & ~mk_m) | (din & mk_m);
      if (clr) mcnt = 16;
    end
  end

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rv_a === 1'b1) begin
      total = total + 1;
      if (qa.size() == 0) begin
        bad = bad + 1;
        $display("FAIL sb_a_unexpected cyc=%0d dout=%h", cyc, dout_a);
      end else begin
        ea = qa.pop_front();
        last_a = ea.dat;
        if (dout_a !== ea.dat || cyc != ea.due) begin
          bad = bad + 1;
          $display("FAIL sb_a_data got=%h@%0d want=%h@%0d", dout_a, cyc, ea.dat, ea.due);
        end
      end
    end else if (qa.size() != 0 && qa[0].due <= cyc) begin
      total = total + 1;
      bad = bad + 1;
      ea = qa.pop_front();
      $display("FAIL sb_a_missing got=no_rvalid@%0d want=%h@%0d", cyc, ea.dat, ea.due);
    end
    if (rv_b === 1'b1) begin
      total = total + 1;
      if (qb.size() == 0) begin
        bad = bad + 1;
        $display("FAIL sb_b_unexpected cyc=%0d dout=%h", cyc, dout_b);
      end else begin
        eb = qb.pop_front();
        last_b = eb.dat;
        if (dout_b !== eb.dat || cyc != eb.due) begin
          bad = bad + 1;
          $display("FAIL sb_b_data got=%h@%0d want=%h@%0d", dout_b, cyc, eb.dat, eb.due);
        end
      end
    end else if (qb.size() != 0 && qb[0].due <= cyc) begin
      total = total + 1;
      bad = bad + 1;
      eb = qb.pop_front();
      $display("FAIL sb_b_missing got=no_rvalid@%0d want=%h@%0d", cyc, eb.dat, eb.due);
    end
  end

  task automatic drive(input logic w, input logic [3:0] a_w, input logic [31:0] d,
                       input logic [3:0] b, input logic r, input logic [3:0] a_r,
                       input logic c, input logic rs);
    @(posedge clk);
    #1;
    we = w; wa = a_w; din = d; be = b; re = r; ra = a_r; clr = c; rst = rs;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a === 1'b1) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    int n;
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1 || rv_a !== 1'b0 || rv_b !== 1'b0 ||
        dout_a !== 32'd0 || dout_b !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got busy=%b%b rv=%b%b dout=%h/%h want busy=11 rv=00 dout=0",
               busy_a, busy_b, rv_a, rv_b, dout_a, dout_b);
    end
    idle();
    count_busy(n);
    total++;
    if (n != 16 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_clear_len got=%0d busy_b=%b want=16 busy_b=0", n, busy_b);
    end
  endtask

  task automatic test_clear_read();
    for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i), 1'b0, 1'b0);
    idle();
    idle();
    idle();
    @(negedge clk);
    total++;
    if (dout_a !== CV || dout_b !== CV) begin
      bad++;
      $display("FAIL clear_hold got=%h/%h want=%h", dout_a, dout_b, CV);
    end
  endtask

  task automatic test_byte_merge();
    drive(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd3, 32'h1122_3344, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    total++;
    if (rv_a !== 1'b1 || dout_a !== 32'hDE22_BE44) begin
      bad++;
      $display("FAIL merge_lat1 got rv=%b dout=%h want rv=1 dout=de22be44", rv_a, dout_a);
    end
    idle();
    @(negedge clk);
    total++;
    if (rv_b !== 1'b1 || dout_b !== 32'hDE22_BE44) begin
      bad++;
      $display("FAIL merge_lat2 got rv=%b dout=%h want rv=1 dout=de22be44", rv_b, dout_b);
    end
  endtask

  task automatic test_rdw();
    drive(1'b1, 4'd5, 32'hAAAA_AAAA, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd5, 32'h5555_5555, 4'b0011, 1'b1, 4'd5, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (dout_a !== 32'hAAAA_5555) begin
      bad++;
      $display("FAIL rdw_new got=%h want=aaaa5555", dout_a);
    end
    idle();
    @(negedge clk);
    total++;
    if (dout_b !== 32'hAAAA_AAAA || dout_a !== 32'hAAAA_5555) begin
      bad++;
      $display("FAIL rdw_old_next got b=%h a=%h want b=aaaaaaaa a=aaaa5555", dout_b, dout_a);
    end
    idle();
    @(negedge clk);
    total++;
    if (dout_b !== 32'hAAAA_5555) begin
      bad++;
      $display("FAIL rdw_after_write got=%h want=aaaa5555", dout_b);
    end
  endtask

  task automatic test_clear_req();
    int n, nrv;
    n = 0;
    nrv = 0;
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 32'hF000_0000 | 32'(i), 4'hF, 1'b1, 4'(i), (i == 4), 1'b0);
      @(negedge clk);
      if (busy_a === 1'b1) n++;
      if (rv_a === 1'b1 || rv_b === 1'b1) nrv++;
    end
    idle();
    @(negedge clk);
    total++;
    if (n != 16 || busy_a !== 1'b0 || nrv != 0) begin
      bad++;
      $display("FAIL clr_req got busy_cycles=%0d busy_after=%b rvalids=%0d want 16/0/0",
               n, busy_a, nrv);
    end
    for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i), 1'b0, 1'b0);
    idle();
    idle();
    idle();
    @(negedge clk);
    total++;
    if (dout_a !== CV || dout_b !== CV) begin
      bad++;
      $display("FAIL clr_req_data got=%h/%h want=%h", dout_a, dout_b, CV);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle();
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle();
    count_busy(n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL rst_mid_clear got=%0d want=16", n);
    end
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    total++;
    if (rv_a !== 1'b0 || rv_b !== 1'b0 || dout_a !== 32'd0 || dout_b !== 32'd0) begin
      bad++;
      $display("FAIL rst_flush got rv=%b%b dout=%h/%h want rv=00 dout=0/0",
               rv_a, rv_b, dout_a, dout_b);
    end
    count_busy(n);
    total++;
    if (n != 15) begin
      bad++;
      $display("FAIL rst_flush_clear got=%0d want=15", n);
    end
  endtask

  task automatic test_back_to_back();
    int na, nb;
    na = 0;
    nb = 0;
    for (int i = 0; i < 16; i++)
      drive(1'b1, 4'(i), {4{8'(i * 17)}} ^ 32'h0F1E_2D3C, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(i), 1'b0, 1'b0);
      @(negedge clk);
      if (rv_a === 1'b1) na++;
      if (rv_b === 1'b1) nb++;
    end
    for (int j = 0; j < 4; j++) begin
      idle();
      @(negedge clk);
      if (rv_a === 1'b1) na++;
      if (rv_b === 1'b1) nb++;
    end
    total++;
    if (na != 16 || nb != 16) begin
      bad++;
      $display("FAIL b2b_count got=%0d/%0d want=16/16", na, nb);
    end
    total++;
    if (rv_a !== 1'b0 || dout_a !== last_a || dout_b !== last_b) begin
      bad++;
      $display("FAIL b2b_hold got rv=%b dout=%h/%h want rv=0 dout=%h/%h",
               rv_a, dout_a, dout_b, last_a, last_b);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    mcnt  = 0;
    last_a = '0;
    last_b = '0;
    for (int i = 0; i < 16; i++) m[i] = CV;
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
    wa = '0; ra = '0; be = '0; din = '0;
    test_reset();
    test_clear_read();
    test_byte_merge();
    test_rdw();
    test_clear_req();
    test_reset_mid();
    test_back_to_back();
    idle();
    idle();
    @(negedge clk);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d/%0d pending want=0/0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
